// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I(+M) decode stage: opcodes, ALU operation
// codes and the control bundle produced by the combinational decoder.
package decode_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] RXX   = 7'b0110011;
    localparam logic [6:0] IXX   = 7'b0010011;
    localparam logic [6:0] BXX   = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LXX   = 7'b0000011;
    localparam logic [6:0] SXX   = 7'b0100011;

    // funct7 values that qualify R-type and shift-immediate encodings
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // ALU operation codes; base-ISA ops equal funct3, SUB/SRA add 8,
    // branches and M-extension ops are a base plus funct3.
    localparam logic [5:0] ALU_ADD     = 6'd0;
    localparam logic [5:0] ALU_SLL     = 6'd1;
    localparam logic [5:0] ALU_SLT     = 6'd2;
    localparam logic [5:0] ALU_SLTU    = 6'd3;
    localparam logic [5:0] ALU_XOR     = 6'd4;
    localparam logic [5:0] ALU_SRL     = 6'd5;
    localparam logic [5:0] ALU_OR      = 6'd6;
    localparam logic [5:0] ALU_AND     = 6'd7;
    localparam logic [5:0] ALU_SUB     = 6'd8;
    localparam logic [5:0] ALU_SRA     = 6'd13;
    localparam logic [5:0] ALU_PASSB   = 6'd16;
    localparam logic [5:0] ALU_ADDPC   = 6'd17;
    localparam logic [5:0] ALU_LINK    = 6'd18;
    localparam logic [5:0] ALU_BR_BASE = 6'd24;
    localparam logic [5:0] ALU_M_BASE  = 6'd32;

    // Control bundle for one decoded instruction
    typedef struct packed {
        logic [5:0] alu_op;
        logic       alusrc;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // Combine an ALU op base with funct3 (bases are 8-aligned)
    function automatic logic [5:0] alu_with_f3(input logic [5:0] base, input logic [2:0] f3);
        return base | {3'b000, f3};
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) decoder: control bundle, sign-extended
// immediate and register addresses (zeroed when the format does not use them).
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ENABLE_M   = 0
) (
    input  logic [31:0]           instruction,
    output ctrl_t                 ctrl,
    output logic [XLEN-1:0]       imm,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sel;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Opcode/funct decode into the control bundle; illegal encodings drop all side effects
    always_comb begin
        ctrl    = '0;
        imm_sel = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            RXX: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                use_rd         = 1'b1;
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE) begin
                    ctrl.alu_op = alu_with_f3(ALU_ADD, funct3);
                end else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
                    ctrl.alu_op = alu_with_f3(ALU_SUB, funct3);
                end else if (funct7 == F7_MEXT && ENABLE_M != 0) begin
                    ctrl.alu_op = alu_with_f3(ALU_M_BASE, funct3);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            IXX: begin
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = imm_i;
                ctrl.alu_op    = alu_with_f3(ALU_ADD, funct3);
                if (funct3 == 3'd1) begin
                    if (funct7 != F7_BASE) ctrl.illegal = 1'b1;
                end else if (funct3 == 3'd5) begin
                    if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE) ctrl.illegal = 1'b1;
                end
            end
            LUI: begin
                use_rd         = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alusrc    = 1'b1;
                imm_sel        = imm_u;
                ctrl.alu_op    = ALU_PASSB;
            end
            AUIPC: begin
                use_rd         = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alusrc    = 1'b1;
                imm_sel        = imm_u;
                ctrl.alu_op    = ALU_ADDPC;
            end
            JAL: begin
                use_rd         = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_sel        = imm_j;
                ctrl.alu_op    = ALU_LINK;
            end
            JALR: begin
                use_rs1        = 1'b1;
                use_rd         = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alusrc    = 1'b1;
                imm_sel        = imm_i;
                ctrl.alu_op    = ALU_LINK;
            end
            BXX: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                ctrl.branch = 1'b1;
                imm_sel     = imm_b;
                ctrl.alu_op = alu_with_f3(ALU_BR_BASE, funct3);
                if (funct3 == 3'd2 || funct3 == 3'd3) ctrl.illegal = 1'b1;
            end
            LXX: begin
                use_rs1         = 1'b1;
                use_rd          = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alusrc     = 1'b1;
                imm_sel         = imm_i;
                ctrl.alu_op     = ALU_ADD;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) ctrl.illegal = 1'b1;
            end
            SXX: begin
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alusrc    = 1'b1;
                imm_sel        = imm_s;
                ctrl.alu_op    = ALU_ADD;
                if (funct3 > 3'd2) ctrl.illegal = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (ctrl.illegal) begin
            ctrl.reg_write  = 1'b0;
            ctrl.mem_read   = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.mem_to_reg = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.jump       = 1'b0;
        end
    end

    // Register fields are reported only when the format reads/writes them
    always_comb begin
        rs1 = use_rs1 ? REG_ADDR_W'(instruction[19:15]) : '0;
        rs2 = use_rs2 ? REG_ADDR_W'(instruction[24:20]) : '0;
        rd  = use_rd  ? REG_ADDR_W'(instruction[11:7])  : '0;
        imm = XLEN'($signed(imm_sel));
    end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode pipeline stage between fetch and execute.
// Owns the handshake, the one-entry output register, the load-use interlock,
// flush and a saturating interlock-cycle counter.
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both high. instr_ready_o is combinational and never looks at
// instr_valid_i; the held bundle stays stable while id_valid_o & !id_ready_i.
// flush_i drops id_valid_o on the next edge regardless of accept or hold.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ALU_OP_W    = 6,
    parameter int ENABLE_M    = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [31:0]            instruction_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   flush_i,
    input  logic                   ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0]  ex_rd_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [XLEN-1:0]        pc_o,
    output logic [REG_ADDR_W-1:0]  rs1_o,
    output logic [REG_ADDR_W-1:0]  rs2_o,
    output logic [REG_ADDR_W-1:0]  rd_o,
    output logic [XLEN-1:0]        imm_o,
    output logic [ALU_OP_W-1:0]    alu_op_o,
    output logic                   alusrc_o,
    output logic                   mem_to_reg_o,
    output logic                   reg_write_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic                   branch_o,
    output logic                   jump_o,
    output logic                   illegal_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    ctrl_t                 dec_ctrl;
    logic [XLEN-1:0]       dec_imm;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  hazard;
    logic                  accept;

    decode_comb #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .ENABLE_M   (ENABLE_M)
    ) u_decode_comb (
        .instruction (instruction_i),
        .ctrl        (dec_ctrl),
        .imm         (dec_imm),
        .rs1         (dec_rs1),
        .rs2         (dec_rs2),
        .rd          (dec_rd)
    );

    // Load-use interlock; unused rs fields are already zero and x0 never hazards
    always_comb begin
        hazard = ex_mem_read_i && (ex_rd_i != '0) &&
                 ((ex_rd_i == dec_rs1) || (ex_rd_i == dec_rs2));
        instr_ready_o = (!id_valid_o || id_ready_i) && !hazard;
        accept        = instr_valid_i && instr_ready_o;
    end

    // Output valid: flush wins, then accept, then bubble on consume
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_valid_o <= 1'b0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (accept) begin
            id_valid_o <= 1'b1;
        end else if (id_ready_i) begin
            id_valid_o <= 1'b0;
        end
    end

    // Bundle register: loads on accept only, so a held bundle never moves
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o         <= '0;
            rs1_o        <= '0;
            rs2_o        <= '0;
            rd_o         <= '0;
            imm_o        <= '0;
            alu_op_o     <= '0;
            alusrc_o     <= 1'b0;
            mem_to_reg_o <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            branch_o     <= 1'b0;
            jump_o       <= 1'b0;
            illegal_o    <= 1'b0;
        end else if (accept) begin
            pc_o         <= pc_i;
            rs1_o        <= dec_rs1;
            rs2_o        <= dec_rs2;
            rd_o         <= dec_rd;
            imm_o        <= dec_imm;
            alu_op_o     <= ALU_OP_W'(dec_ctrl.alu_op);
            alusrc_o     <= dec_ctrl.alusrc;
            mem_to_reg_o <= dec_ctrl.mem_to_reg;
            reg_write_o  <= dec_ctrl.reg_write;
            mem_read_o   <= dec_ctrl.mem_read;
            mem_write_o  <= dec_ctrl.mem_write;
            branch_o     <= dec_ctrl.branch;
            jump_o       <= dec_ctrl.jump;
            illegal_o    <= dec_ctrl.illegal;
        end
    end

    // Saturating count of cycles a valid instruction was blocked by the interlock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (instr_valid_i && hazard && !flush_i &&
                     (stall_cnt_o != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with the M extension off and
// a 16-bit stall counter, one with M on and a 4-bit counter, sharing inputs.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        id_ready;

    logic        instr_ready, id_valid;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [5:0]  alu_op;
    logic        alusrc, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [15:0] stall_cnt;

    logic        m_instr_ready, m_id_valid;
    logic [31:0] m_pc_o, m_imm_o;
    logic [4:0]  m_rs1_o, m_rs2_o, m_rd_o;
    logic [5:0]  m_alu_op;
    logic        m_alusrc, m_mem_to_reg, m_reg_write, m_mem_read, m_mem_write;
    logic        m_branch, m_jump, m_illegal;
    logic [3:0]  m_stall_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_stall;

    decode_stage #(.ENABLE_M(0)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instruction_i(instruction), .pc_i(pc), .flush_i(flush),
        .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
        .id_valid_o(id_valid), .id_ready_i(id_ready), .pc_o(pc_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .imm_o(imm_o), .alu_op_o(alu_op),
        .alusrc_o(alusrc), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .branch_o(branch),
        .jump_o(jump), .illegal_o(illegal), .stall_cnt_o(stall_cnt)
    );

    decode_stage #(.ENABLE_M(1), .STALL_CNT_W(4)) dut_m (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(m_instr_ready),
        .instruction_i(instruction), .pc_i(pc), .flush_i(flush),
        .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
        .id_valid_o(m_id_valid), .id_ready_i(id_ready), .pc_o(m_pc_o),
        .rs1_o(m_rs1_o), .rs2_o(m_rs2_o), .rd_o(m_rd_o), .imm_o(m_imm_o), .alu_op_o(m_alu_op),
        .alusrc_o(m_alusrc), .mem_to_reg_o(m_mem_to_reg), .reg_write_o(m_reg_write),
        .mem_read_o(m_mem_read), .mem_write_o(m_mem_write), .branch_o(m_branch),
        .jump_o(m_jump), .illegal_o(m_illegal), .stall_cnt_o(m_stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(id_valid), 64'd0);
        chk({tag, "_pc"}, 64'(pc_o), 64'd0);
        chk({tag, "_regs"}, 64'({rs1_o, rs2_o, rd_o}), 64'd0);
        chk({tag, "_imm"}, 64'(imm_o), 64'd0);
        chk({tag, "_alu"}, 64'(alu_op), 64'd0);
        chk({tag, "_flags"}, 64'({alusrc, mem_to_reg, reg_write, mem_read, mem_write,
                                  branch, jump, illegal}), 64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_m_valid"}, 64'(m_id_valid), 64'd0);
        chk({tag, "_m_stall"}, 64'(m_stall_cnt), 64'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1; instr_valid = 1'b0; instruction = '0; pc = '0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; id_ready = 1'b1; exp_stall = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("reset_ready", 64'(instr_ready), 64'd1);

        // 1: ADDI x5,x1,-1
        instruction = 32'hFFF08293; pc = 32'h100; instr_valid = 1'b1;
        #1;
        chk("addi_ready", 64'(instr_ready), 64'd1);
        tick();
        chk("addi_valid", 64'(id_valid), 64'd1);
        chk("addi_rd", 64'(rd_o), 64'd5);
        chk("addi_rs1", 64'(rs1_o), 64'd1);
        chk("addi_rs2", 64'(rs2_o), 64'd0);
        chk("addi_imm", 64'(imm_o), 64'hFFFFFFFF);
        chk("addi_alu", 64'(alu_op), 64'd0);
        chk("addi_alusrc", 64'(alusrc), 64'd1);
        chk("addi_regwrite", 64'(reg_write), 64'd1);
        chk("addi_pc", 64'(pc_o), 64'h100);

        // 2: ADD x4,x3,x1 behind a load to x3 for two cycles
        instruction = 32'h00118233; pc = 32'h104; ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        chk("hz_ready_c1", 64'(instr_ready), 64'd0);
        tick();
        exp_stall = exp_stall + 16'd1;
        chk("hz_bubble", 64'(id_valid), 64'd0);
        chk("hz_stall_1", 64'(stall_cnt), 64'(exp_stall));
        chk("hz_ready_c2", 64'(instr_ready), 64'd0);
        tick();
        exp_stall = exp_stall + 16'd1;
        chk("hz_stall_2", 64'(stall_cnt), 64'(exp_stall));
        chk("hz_m_stall_2", 64'(m_stall_cnt), 64'd2);
        chk("hz_valid_c2", 64'(id_valid), 64'd0);
        ex_mem_read = 1'b0;
        #1;
        chk("hz_ready_c3", 64'(instr_ready), 64'd1);
        tick();
        chk("add_valid", 64'(id_valid), 64'd1);
        chk("add_regs", 64'({rs1_o, rs2_o, rd_o}), 64'({5'd3, 5'd1, 5'd4}));
        chk("add_alusrc", 64'(alusrc), 64'd0);
        chk("add_regwrite", 64'(reg_write), 64'd1);
        chk("add_stall_kept", 64'(stall_cnt), 64'(exp_stall));

        // Hazard field boundaries (combinational only, no edge in between)
        ex_mem_read = 1'b1; ex_rd = 5'd3; instruction = 32'h000182B7; // LUI, bits[19:15]=3
        #1;
        chk("u_ignores_rs1", 64'(instr_ready), 64'd1);
        ex_rd = 5'd0; instruction = 32'h00500093;                      // ADDI x1,x0,5
        #1;
        chk("x0_no_hazard", 64'(instr_ready), 64'd1);
        ex_rd = 5'd31; instruction = 32'hFFF08293;                     // bits[24:20]=31
        #1;
        chk("i_ignores_rs2", 64'(instr_ready), 64'd1);
        ex_rd = 5'd1; instruction = 32'h00118233;                      // ADD rs2=x1
        #1;
        chk("r_rs2_hazard", 64'(instr_ready), 64'd0);
        instr_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        tick();
        chk("bubble_after_consume", 64'(id_valid), 64'd0);

        // 3: hold for three cycles, then back-to-back accepts
        instruction = 32'h00700313; pc = 32'h200; instr_valid = 1'b1;
        exp_q.push_back(32'h200);
        tick();
        chk("hold_first_valid", 64'(id_valid), 64'd1);
        chk("hold_first_pc", 64'(pc_o), 64'(exp_q.pop_front()));
        id_ready = 1'b0; instruction = 32'h00A00393; pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_ready_%0d", k), 64'(instr_ready), 64'd0);
            tick();
            chk($sformatf("hold_valid_%0d", k), 64'(id_valid), 64'd1);
            chk($sformatf("hold_pc_%0d", k), 64'(pc_o), 64'h200);
            chk($sformatf("hold_rd_%0d", k), 64'(rd_o), 64'd6);
            chk($sformatf("hold_imm_%0d", k), 64'(imm_o), 64'd7);
        end
        id_ready = 1'b1;
        exp_q.push_back(32'h204);
        #1;
        chk("b2b_ready_1", 64'(instr_ready), 64'd1);
        tick();
        chk("b2b_pc_1", 64'(pc_o), 64'(exp_q.pop_front()));
        chk("b2b_rd_1", 64'(rd_o), 64'd7);
        instruction = 32'h00B00413; pc = 32'h208;
        exp_q.push_back(32'h208);
        #1;
        chk("b2b_ready_2", 64'(instr_ready), 64'd1);
        tick();
        chk("b2b_valid_2", 64'(id_valid), 64'd1);
        chk("b2b_pc_2", 64'(pc_o), 64'(exp_q.pop_front()));
        chk("b2b_imm_2", 64'(imm_o), 64'd11);

        // 4: flush during accept of LW x3,0(x2)
        instruction = 32'h00012183; pc = 32'h300; flush = 1'b1;
        tick();
        chk("flush_accept", 64'(id_valid), 64'd0);
        flush = 1'b0; instr_valid = 1'b0;
        tick();
        chk("flush_no_load", 64'(id_valid), 64'd0);
        // Flush overrides a hold
        instruction = 32'h00700313; pc = 32'h310; instr_valid = 1'b1;
        tick();
        id_ready = 1'b0; instr_valid = 1'b0;
        tick();
        chk("flush_pre_hold", 64'(id_valid), 64'd1);
        flush = 1'b1;
        tick();
        chk("flush_hold", 64'(id_valid), 64'd0);
        // Flushed hazard cycles are not counted
        id_ready = 1'b1; instruction = 32'h00012183; ex_mem_read = 1'b1; ex_rd = 5'd2;
        instr_valid = 1'b1;
        #1;
        chk("flush_hz_ready", 64'(instr_ready), 64'd0);
        tick();
        chk("flush_hz_stall", 64'(stall_cnt), 64'(exp_stall));
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;

        // 5: MUL x1,x2,x3 with and without the M extension
        instruction = 32'h023100B3; pc = 32'h400;
        tick();
        chk("mul_valid", 64'(id_valid), 64'd1);
        chk("mul_illegal", 64'(illegal), 64'd1);
        chk("mul_regwrite", 64'(reg_write), 64'd0);
        chk("mulm_illegal", 64'(m_illegal), 64'd0);
        chk("mulm_alu", 64'(m_alu_op), 64'd32);
        chk("mulm_regwrite", 64'(m_reg_write), 64'd1);
        chk("mulm_regs", 64'({m_rs1_o, m_rs2_o, m_rd_o}), 64'({5'd2, 5'd3, 5'd1}));
        instruction = 32'h00000463; pc = 32'h404;                      // BEQ x0,x0,+8
        tick();
        chk("beq_branch", 64'(branch), 64'd1);
        chk("beq_imm", 64'(imm_o), 64'd8);
        chk("beq_alu", 64'(alu_op), 64'd24);
        chk("beq_rd", 64'(rd_o), 64'd0);
        chk("beq_regwrite", 64'(reg_write), 64'd0);
        instruction = 32'h0020A223; pc = 32'h408;                      // SW x2,4(x1)
        tick();
        chk("sw_flags", 64'({mem_write, alusrc, reg_write, mem_read}), 64'b1100);
        chk("sw_imm", 64'(imm_o), 64'd4);
        chk("sw_regs", 64'({rs1_o, rs2_o, rd_o}), 64'({5'd1, 5'd2, 5'd0}));
        chk("sw_alu", 64'(alu_op), 64'd0);
        instruction = 32'h00002063;                                    // branch funct3=2
        tick();
        chk("badbr_illegal", 64'(illegal), 64'd1);
        chk("badbr_branch", 64'(branch), 64'd0);
        instruction = 32'h403100B3;                                    // SUB x1,x2,x3
        tick();
        chk("sub_alu", 64'(alu_op), 64'd8);
        instruction = 32'h40315093;                                    // SRAI x1,x2,3
        tick();
        chk("srai_alu", 64'(alu_op), 64'd13);
        chk("srai_alusrc", 64'(alusrc), 64'd1);
        chk("srai_illegal", 64'(illegal), 64'd0);

        // 6: long interlock while holding, counter saturation, reset mid-hold
        instruction = 32'h00700313; pc = 32'h500;
        tick();
        id_ready = 1'b0; instruction = 32'h00118233; ex_mem_read = 1'b1; ex_rd = 5'd3;
        for (int k = 0; k < 19; k++) begin
            tick();
            exp_stall = exp_stall + 16'd1;
        end
        chk("sat_hold_valid", 64'(id_valid), 64'd1);
        chk("sat_hold_pc", 64'(pc_o), 64'h500);
        chk("sat_stall16", 64'(stall_cnt), 64'(exp_stall));
        chk("sat_stall4", 64'(m_stall_cnt), 64'hF);
        rst = 1'b1;
        tick();
        chk_all_zero("midhold_reset");
        rst = 1'b0; instr_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_ready = 1'b1;
        #1;
        chk("post_reset_ready", 64'(instr_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
